// File: rtl/psram_ram_wr_ctrl_if.sv
// Handshake/bus bundle for psram_ram_wr_ctrl: upstream word stream and SRAM write port.
// master = the write controller, slave = the rx buffer / SRAM arbiter side.
interface psram_ram_wr_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic          ram_wr_req;
  logic          ram_wr_ack;
  logic [DW-1:0] ram_wdata;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_gnt;

  modport master (
    input  ram_wr_req,
    input  ram_wdata,
    input  sram_gnt,
    output ram_wr_ack,
    output sram_cs,
    output sram_we,
    output sram_addr,
    output sram_wdata
  );

  modport slave (
    output ram_wr_req,
    output ram_wdata,
    output sram_gnt,
    input  ram_wr_ack,
    input  sram_cs,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata
  );
endinterface

// File: rtl/psram_ram_wr_ctrl.sv
// Writes the PSRAM rx word stream into the read-data SRAM through a 2-entry FIFO.
// Optional byte parity output sram_wpar when PSRAM_RAM_WR_PARITY_EN is defined.
module psram_ram_wr_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic                hclk,
  input  logic                hrstn,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         word_len,
  psram_ram_wr_ctrl_if.master bus,
`ifdef PSRAM_RAM_WR_PARITY_EN
  output logic [DW/8-1:0]     sram_wpar,
`endif
  output logic                busy,
  output logic                done,
  output logic [AW:0]         wr_cnt,
  output logic                drop_err
);

  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drop_err_q, drop_err_d;
  logic [AW:0]        wr_cnt_q, wr_cnt_d;
  logic [AW:0]        len_q, len_d;
  logic [AW-1:0]      addr_q, addr_d;

  logic               pop, accept, push;
  logic [AW+1:0]      pending;
  logic [AW:0]        wr_cnt_inc;

`ifdef PSRAM_RAM_WR_PARITY_EN
  logic [1:0][DW/8-1:0] par_q, par_d;
  logic [DW/8-1:0]      par_in;

  always_comb begin
    par_in = '0;
    for (int i = 0; i < int'(DW / 8); i++) begin
      par_in[i] = ^bus.ram_wdata[8*i +: 8];
    end
  end
`endif

  always_comb begin
    pop        = (cnt_q != 2'd0) && bus.sram_gnt;
    accept     = bus.ram_wr_req && !ack_q && !start && ((cnt_q != 2'd2) || pop);
    // Words already committed to this transfer; anything beyond word_len is dropped.
    pending    = {1'b0, wr_cnt_q} + {{AW{1'b0}}, cnt_q};
    push       = accept && busy_q && (pending < {1'b0, len_q});
    wr_cnt_inc = wr_cnt_q + (AW+1)'(1);

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    drop_err_d = drop_err_q;
    wr_cnt_d   = wr_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
`ifdef PSRAM_RAM_WR_PARITY_EN
    par_d      = par_q;
`endif

    if (start) begin
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
      drop_err_d = 1'b0;
      wr_cnt_d   = '0;
      len_d      = word_len;
      addr_d     = base_addr;
      busy_d     = (word_len != '0);
      done_d     = (word_len == '0);
    end else begin
      ack_d = accept;
      if (accept && !push) begin
        drop_err_d = 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q] = bus.ram_wdata;
`ifdef PSRAM_RAM_WR_PARITY_EN
        par_d[wr_ptr_q] = par_in;
`endif
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        addr_d   = addr_q + AW'(1);
        wr_cnt_d = wr_cnt_inc;
        if (wr_cnt_inc == len_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrstn) begin
      mem_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_err_q <= 1'b0;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
`ifdef PSRAM_RAM_WR_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_err_q <= drop_err_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
`ifdef PSRAM_RAM_WR_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.ram_wr_ack = ack_q;
  assign bus.sram_cs    = (cnt_q != 2'd0);
  assign bus.sram_we    = (cnt_q != 2'd0);
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = mem_q[rd_ptr_q];
`ifdef PSRAM_RAM_WR_PARITY_EN
  assign sram_wpar      = par_q[rd_ptr_q];
`endif
  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_cnt         = wr_cnt_q;
  assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_psram_ram_wr_ctrl.sv
// Directed self-checking bench for psram_ram_wr_ctrl; parity check built only when
// PSRAM_RAM_WR_PARITY_EN is defined.
module tb_psram_ram_wr_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          hclk = 1'b0;
  logic          hrstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_len = '0;
  logic          busy, done, drop_err;
  logic [AW:0]   wr_cnt;
`ifdef PSRAM_RAM_WR_PARITY_EN
  logic [DW/8-1:0] sram_wpar;
`endif

  psram_ram_wr_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  psram_ram_wr_ctrl #(.AW(AW), .DW(DW)) dut (
    .hclk      (hclk),
    .hrstn     (hrstn),
    .start     (start),
    .base_addr (base_addr),
    .word_len  (word_len),
    .bus       (bus.master),
`ifdef PSRAM_RAM_WR_PARITY_EN
    .sram_wpar (sram_wpar),
`endif
    .busy      (busy),
    .done      (done),
    .wr_cnt    (wr_cnt),
    .drop_err  (drop_err)
  );

  always #5 hclk = ~hclk;

  int n_pass = 0;
  int n_total = 0;
  int ack_cnt = 0;
  int ack_base = 0;
  int log_base = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  // Mid-cycle monitor: completed SRAM writes and ack pulses.
  always @(negedge hclk) begin
    if (bus.ram_wr_ack === 1'b1) ack_cnt++;
    if (bus.sram_cs === 1'b1 && bus.sram_gnt === 1'b1) begin
      log_addr.push_back(bus.sram_addr);
      log_data.push_back(bus.sram_wdata);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1;
    base_addr = b;
    word_len = l;
    tick();
    start = 1'b0;
    ack_base = ack_cnt;
    log_base = log_addr.size();
  endtask

  task automatic send_word(input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    bus.ram_wr_req = 1'b1;
    bus.ram_wdata = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ram_wr_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.ram_wr_req = 1'b0;
    tick();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    hrstn = 1'b0;
    tick(2);
    n_total++; if (bus.ram_wr_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.ram_wr_ack); else n_pass++;
    n_total++; if (bus.sram_cs !== 1'b0 || bus.sram_we !== 1'b0) $display("FAIL reset_cs_we: got %b%b want 00", bus.sram_cs, bus.sram_we); else n_pass++;
    n_total++; if (bus.sram_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.sram_addr); else n_pass++;
    n_total++; if (bus.sram_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.sram_wdata); else n_pass++;
    n_total++; if ({busy, done, drop_err} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, drop_err}); else n_pass++;
    n_total++; if (wr_cnt !== 9'd0) $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); else n_pass++;
    hrstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    bit all_ok;
    logic [DW-1:0] exp_d[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    bus.sram_gnt = 1'b1;
    do_start(8'h10, 9'd4);
    n_total++; if ({busy, done} !== 2'b10) $display("FAIL basic_start_status: got %b want 10", {busy, done}); else n_pass++;
    // First word by hand to pin down the N+1 / N+2 latency.
    bus.ram_wr_req = 1'b1;
    bus.ram_wdata = 32'hA0;
    tick();
    n_total++; if (bus.ram_wr_ack !== 1'b1 || bus.sram_cs !== 1'b1) $display("FAIL basic_n1_ack_cs: got %b%b want 11", bus.ram_wr_ack, bus.sram_cs); else n_pass++;
    n_total++; if (bus.sram_wdata !== 32'hA0 || bus.sram_addr !== 8'h10) $display("FAIL basic_n1_word: got %h@%h want a0@10", bus.sram_wdata, bus.sram_addr); else n_pass++;
    bus.ram_wr_req = 1'b0;
    tick();
    n_total++; if (wr_cnt !== 9'd1) $display("FAIL basic_n2_wr_cnt: got %0d want 1", wr_cnt); else n_pass++;
    all_ok = 1'b1;
    for (int i = 1; i < 4; i++) begin
      send_word(exp_d[i], ok);
      all_ok &= ok;
    end
    n_total++; if (all_ok !== 1'b1) $display("FAIL basic_acks_seen: got %b want 1", all_ok); else n_pass++;
    n_total++; if ({busy, done} !== 2'b01) $display("FAIL basic_done_m1: got %b want 01", {busy, done}); else n_pass++;
    n_total++; if (wr_cnt !== 9'd4) $display("FAIL basic_wr_cnt: got %0d want 4", wr_cnt); else n_pass++;
    n_total++; if (ack_cnt - ack_base !== 4) $display("FAIL basic_ack_pulses: got %0d want 4", ack_cnt - ack_base); else n_pass++;
    n_total++; if (log_addr.size() - log_base !== 4) $display("FAIL basic_write_count: got %0d want 4", log_addr.size() - log_base); else n_pass++;
    for (int i = 0; i < 4 && log_base + i < log_addr.size(); i++) begin
      n_total++;
      if (log_addr[log_base+i] !== 8'h10 + 8'(i) || log_data[log_base+i] !== exp_d[i])
        $display("FAIL basic_write%0d: got %h@%h want %h@%h", i, log_data[log_base+i], log_addr[log_base+i], exp_d[i], 8'h10 + 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] exp_a[3] = '{8'hFE, 8'hFF, 8'h00};
    logic [DW-1:0] exp_d[3] = '{32'hB0, 32'hB1, 32'hB2};
    bus.sram_gnt = 1'b1;
    do_start(8'hFE, 9'd3);
    for (int i = 0; i < 3; i++) send_word(exp_d[i], ok);
    wait_done(ok);
    n_total++; if (ok !== 1'b1) $display("FAIL wrap_done: got %b want 1", ok); else n_pass++;
    n_total++; if (log_addr.size() - log_base !== 3) $display("FAIL wrap_count: got %0d want 3", log_addr.size() - log_base); else n_pass++;
    for (int i = 0; i < 3 && log_base + i < log_addr.size(); i++) begin
      n_total++;
      if (log_addr[log_base+i] !== exp_a[i] || log_data[log_base+i] !== exp_d[i])
        $display("FAIL wrap_write%0d: got %h@%h want %h@%h", i, log_data[log_base+i], log_addr[log_base+i], exp_d[i], exp_a[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [DW-1:0] exp_d[3] = '{32'hC0, 32'hC1, 32'hC2};
    bus.sram_gnt = 1'b0;
    do_start(8'h40, 9'd3);
    send_word(exp_d[0], ok);
    send_word(exp_d[1], ok);
    bus.ram_wr_req = 1'b1;
    bus.ram_wdata = exp_d[2];
    tick(6);
    n_total++; if (ack_cnt - ack_base !== 2) $display("FAIL stall_acks_held: got %0d want 2", ack_cnt - ack_base); else n_pass++;
    n_total++; if (bus.sram_cs !== 1'b1 || bus.sram_addr !== 8'h40 || bus.sram_wdata !== 32'hC0) $display("FAIL stall_head: got cs=%b %h@%h want cs=1 c0@40", bus.sram_cs, bus.sram_wdata, bus.sram_addr); else n_pass++;
    n_total++; if (wr_cnt !== 9'd0) $display("FAIL stall_wr_cnt: got %0d want 0", wr_cnt); else n_pass++;
    bus.sram_gnt = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ram_wr_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.ram_wr_req = 1'b0;
    n_total++; if (ok !== 1'b1) $display("FAIL stall_third_ack: got %b want 1", ok); else n_pass++;
    wait_done(ok);
    n_total++; if (log_addr.size() - log_base !== 3 || ack_cnt - ack_base !== 3) $display("FAIL stall_counts: got writes=%0d acks=%0d want 3/3", log_addr.size() - log_base, ack_cnt - ack_base); else n_pass++;
    for (int i = 0; i < 3 && log_base + i < log_addr.size(); i++) begin
      n_total++;
      if (log_addr[log_base+i] !== 8'h40 + 8'(i) || log_data[log_base+i] !== exp_d[i])
        $display("FAIL stall_write%0d: got %h@%h want %h@%h", i, log_data[log_base+i], log_addr[log_base+i], exp_d[i], 8'h40 + 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_drop();
    bit ok;
    bus.sram_gnt = 1'b1;
    do_start(8'h20, 9'd2);
    send_word(32'hD0, ok);
    send_word(32'hD1, ok);
    wait_done(ok);
    n_total++; if (drop_err !== 1'b0) $display("FAIL drop_before: got %b want 0", drop_err); else n_pass++;
    send_word(32'hD2, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL drop_extra_acked: got %b want 1", ok); else n_pass++;
    n_total++; if (drop_err !== 1'b1) $display("FAIL drop_err_set: got %b want 1", drop_err); else n_pass++;
    n_total++; if (log_addr.size() - log_base !== 2 || wr_cnt !== 9'd2) $display("FAIL drop_not_written: got writes=%0d wr_cnt=%0d want 2/2", log_addr.size() - log_base, wr_cnt); else n_pass++;
    do_start(8'h30, 9'd1);
    n_total++; if (drop_err !== 1'b0 || busy !== 1'b1) $display("FAIL drop_cleared: got drop=%b busy=%b want 0/1", drop_err, busy); else n_pass++;
  endtask

  task automatic test_back_to_back_start();
    bit ok;
    bus.sram_gnt = 1'b0;
    do_start(8'h50, 9'd4);
    send_word(32'hE0, ok);
    send_word(32'hE1, ok);
    n_total++; if (bus.sram_cs !== 1'b1) $display("FAIL restart_fifo_loaded: got %b want 1", bus.sram_cs); else n_pass++;
    do_start(8'h60, 9'd2);
    n_total++; if (bus.sram_cs !== 1'b0 || wr_cnt !== 9'd0) $display("FAIL restart_flush: got cs=%b wr_cnt=%0d want 0/0", bus.sram_cs, wr_cnt); else n_pass++;
    n_total++; if (bus.sram_addr !== 8'h60 || busy !== 1'b1) $display("FAIL restart_base: got %h busy=%b want 60/1", bus.sram_addr, busy); else n_pass++;
    bus.sram_gnt = 1'b1;
    send_word(32'hF0, ok);
    send_word(32'hF1, ok);
    wait_done(ok);
    n_total++; if (ok !== 1'b1 || log_addr.size() - log_base !== 2) $display("FAIL restart_count: got done=%b writes=%0d want 1/2", ok, log_addr.size() - log_base); else n_pass++;
    if (log_addr.size() - log_base >= 2) begin
      n_total++;
      if (log_addr[log_base] !== 8'h60 || log_data[log_base] !== 32'hF0 || log_addr[log_base+1] !== 8'h61 || log_data[log_base+1] !== 32'hF1)
        $display("FAIL restart_writes: got %h@%h %h@%h want f0@60 f1@61", log_data[log_base], log_addr[log_base], log_data[log_base+1], log_addr[log_base+1]);
      else n_pass++;
    end
    do_start(8'h70, 9'd0);
    n_total++; if ({busy, done, bus.sram_cs} !== 3'b010) $display("FAIL len0: got busy/done/cs=%b want 010", {busy, done, bus.sram_cs}); else n_pass++;
  endtask

`ifdef PSRAM_RAM_WR_PARITY_EN
  task automatic test_parity();
    bit ok;
    bus.sram_gnt = 1'b0;
    do_start(8'h00, 9'd1);
    send_word(32'h01030700, ok);
    n_total++; if (sram_wpar !== 4'b1010) $display("FAIL parity: got %b want 1010", sram_wpar); else n_pass++;
    bus.sram_gnt = 1'b1;
    wait_done(ok);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.ram_wr_req = 1'b0;
    bus.ram_wdata = '0;
    bus.sram_gnt = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_drop();
    test_back_to_back_start();
`ifdef PSRAM_RAM_WR_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psram_ram_wr_ctrl.md
# psram_ram_wr_ctrl

Consumes the word stream that the PSRAM receive buffer presents in the hclk domain (`ram_wr_req`/`ram_wr_ack`/`ram_wdata`) and writes it into the on-chip read-data SRAM.

- Writes go through a 2-entry FIFO, at sequential word addresses starting at a programmed base.
- The SRAM port is arbitrated by a grant input.
- Counts written words against a programmed length and flags completion.
- Sits between the PSRAM rx buffer and the SRAM arbiter.

## Interface
- `AW`, 8, SRAM word-address width; address wraps modulo 2^AW.
- `DW`, 32, data width.

Ports:
- `hclk`  in  1  system clock; single clock domain.
- `hrstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; loads `base_addr`/`word_len`, flushes all state.
- `base_addr`  in  AW  first SRAM word address, sampled on `start`.
- `word_len`  in  AW+1  words to write, 0..2^AW, sampled on `start`.
- `ram_wr_req`  in  1  upstream word valid; held high until acked.
- `ram_wr_ack`  out  1  one-cycle registered accept pulse.
- `ram_wdata`  in  DW  upstream data; stable while `ram_wr_req`=1.
- `sram_cs`  out  1  SRAM access request.
- `sram_we`  out  1  write enable; always equals `sram_cs`.
- `sram_addr`  out  AW  write address.
- `sram_wdata`  out  DW  write data.
- `sram_gnt`  in  1  arbiter grant; a write completes in a cycle with `sram_cs`=1 and `sram_gnt`=1.
- `busy`  out  1  transfer active.
- `done`  out  1  level; all `word_len` words written.
- `wr_cnt`  out  AW+1  words written since `start`.
- `drop_err`  out  1  sticky; a word arrived while not busy.

## Operation
- Reset (`hrstn`=0 at a clock edge) clears everything. All outputs reset to 0, including `sram_addr`, `sram_wdata`, `wr_cnt`, `done` and `drop_err`. FIFO is empty.
- `start` has priority over all other events:
  - flushes the FIFO and discards any unwritten words;
  - clears `wr_cnt`, `done`, `drop_err` and `ram_wr_ack`;
  - sets the write pointer to `base_addr`;
  - `busy`<=1 if `word_len`!=0; otherwise `done`<=1 and `busy`<=0.
- Accept condition, evaluated every cycle:
  - `ram_wr_req`=1 and `ram_wr_ack`=0;
  - not `start`;
  - FIFO not full, or a pop occurs in the same cycle.
- On accept: `ram_wr_ack`<=1 for exactly one cycle. If `busy`=1 the word is pushed into the FIFO. The cycle in which `ack`=1 never re-accepts, because upstream drops `req` the following cycle.
- Word received while `busy`=0 (idle or done): acked normally, data dropped, `drop_err`<=1 until the next `start`. Upstream therefore never hangs.
- FIFO is 2 entries:
  - `sram_cs`=`sram_we`=1 whenever the FIFO is non-empty; `sram_wdata` is the head entry.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - FIFO full means no accept.
- Write completion (`sram_cs`&`sram_gnt`):
  - pop the FIFO;
  - `sram_addr`<=`sram_addr`+1, wrapping from 2^AW-1 to 0;
  - `wr_cnt`<=`wr_cnt`+1.
- When a completion makes `wr_cnt`==`word_len`: `done`<=1 and `busy`<=0. Later words are dropped under the `drop_err` rule.
- No `sram_gnt`: the head entry and `sram_addr` hold; `sram_cs` stays 1.

## Timing
- `req` rising in cycle N (FIFO has room) -> `ram_wr_ack`=1 in N+1 and `sram_cs`=1 with the word in N+1.
- With `sram_gnt`=1 the write completes in N+1. `wr_cnt` updates in N+2.
- Last-word completion in cycle M -> `done`=1 and `busy`=0 in M+1.
- `start` in cycle S -> state flushed and `sram_cs`=0 in S+1. A `req` seen in S is not accepted; it is accepted from S+1.
- Sustained throughput with `gnt` held at 1 is bounded by the upstream handshake. The FIFO absorbs up to 2 words of grant stall before back-pressuring through a withheld `ack`.

## Configuration
- `PSRAM_RAM_WR_PARITY_EN` defined: adds output `sram_wpar` [DW/8-1:0], the even parity of each byte of `sram_wdata`. It is registered alongside the FIFO head and resets to 0.
- `PSRAM_RAM_WR_PARITY_EN` not defined: the port is absent and no parity logic is built. All other behaviour is identical.

## Test plan
- `base_addr`=0x10, `word_len`=4, `gnt` tied 1, four words 0xA0..0xA3 -> SRAM 0x10..0x13 = 0xA0..0xA3; `done`=1 one cycle after the 4th write; `wr_cnt`=4; exactly four `ack` pulses.
- Wrap: `base_addr`=0xFE, `word_len`=3 -> writes land at 0xFE, 0xFF, 0x00.
- `gnt`=0 for 10 cycles while upstream offers 3 words -> 2 acked, 3rd `req` held with no `ack`. After `gnt`=1 all 3 are written in order with none lost.
- Extra word after `done` with `word_len`=2 -> acked, not written, `drop_err`=1; the next `start` clears it.
- `start` mid-transfer (FIFO holding 2 words) -> `sram_cs`=0 next cycle, `wr_cnt`=0, the new transfer begins at the new base, and the old words are never written. `word_len`=0 -> `done`=1 and `busy`=0 one cycle after `start`.
- With `PSRAM_RAM_WR_PARITY_EN`: `sram_wdata`=0x01030700 -> `sram_wpar`=4'b1010 (byte 3 = 0x01, byte 2 = 0x03, byte 1 = 0x07, byte 0 = 0x00).
